button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Two-button conditioner: synchronize, debounce, then turn presses into single-cycle
// count pulses with optional auto-repeat. Simultaneous presses lock out until both release.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_RATE     = 12500000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN0_UP,
  input  logic BTN1_DOWN,
  output logic UP_LEVEL,
  output logic DOWN_LEVEL,
  output logic UP_PULSE,
  output logic DOWN_PULSE
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // state  | meaning
  // IDLE   | no button accepted, waiting for a clean single press
  // DELAY  | first pulse sent, counting towards first auto-repeat
  // REPEAT | auto-repeating every REPEAT_RATE cycles
  // LOCK   | both buttons involved, silent until both are released
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      rise;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;
  state_t          state_nxt;
  logic            dir;
  logic            dir_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic            fire;
  logic            dir_level;
  logic            opp_level;

  assign raw = {BTN1_DOWN, BTN0_UP};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      db_cnt  <= '{default: '0};
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= ~level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Edge detect on the registered level, so the pulse lands one cycle after the level.
  assign rise      = level & ~level_d;
  assign dir_level = (dir == DIR_DOWN) ? level[1] : level[0];
  assign opp_level = (dir == DIR_DOWN) ? level[0] : level[1];

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (rise[0] && rise[1]) begin
          state_nxt = LOCK;
        end else if (rise[0]) begin
          if (level[1]) begin
            state_nxt = LOCK;
          end else begin
            fire      = 1'b1;
            dir_nxt   = DIR_UP;
            timer_nxt = '0;
            state_nxt = DELAY;
          end
        end else if (rise[1]) begin
          if (level[0]) begin
            state_nxt = LOCK;
          end else begin
            fire      = 1'b1;
            dir_nxt   = DIR_DOWN;
            timer_nxt = '0;
            state_nxt = DELAY;
          end
        end
      end
      DELAY: begin
        if (!dir_level) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (opp_level) begin
          timer_nxt = '0;
          state_nxt = LOCK;
        end else if (timer == DELAY_LAST) begin
          // Without auto-repeat the timer parks at its terminal value until release.
          if (REPEAT_EN) begin
            fire      = 1'b1;
            timer_nxt = '0;
            state_nxt = REPEAT;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (!dir_level) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (opp_level) begin
          timer_nxt = '0;
          state_nxt = LOCK;
        end else if (timer == RATE_LAST) begin
          fire      = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      LOCK: begin
        if (level == 2'b00) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      timer      <= '0;
      UP_PULSE   <= 1'b0;
      DOWN_PULSE <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      timer      <= timer_nxt;
      UP_PULSE   <= fire && (dir_nxt == DIR_UP);
      DOWN_PULSE <= fire && (dir_nxt == DIR_DOWN);
    end
  end

  assign UP_LEVEL   = level[0];
  assign DOWN_LEVEL = level[1];

endmodule
